// File: rtl/sv39_ptw_if.sv
// Handshake bundle between the Sv39 walker, its L2 TLB
// requester and the L2 cache port.
interface sv39_ptw_if #(
    parameter int REQ_TAG_WIDTH = 2
);
    logic                     req_valid;
    logic                     req_ready;
    logic [26:0]              req_vpn;
    logic [15:0]              req_asid;
    logic [REQ_TAG_WIDTH-1:0] req_tag;
    logic [43:0]              satp_ppn;
    logic                     flush;
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic [55:0]              mem_req_pa;
    logic                     mem_resp_valid;
    logic [63:0]              mem_resp_pte;
    logic                     mem_resp_error;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [REQ_TAG_WIDTH-1:0] resp_tag;
    logic [15:0]              resp_asid;
    logic [26:0]              resp_vpn;
    logic [34:0]              resp_pte;
    logic [1:0]               resp_level;
    logic                     resp_page_fault;
    logic                     resp_access_fault;

    modport master (
        output req_valid, req_vpn, req_asid, req_tag,
        output satp_ppn, flush,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_pte, mem_resp_error,
        output resp_ready,
        input  req_ready, mem_req_valid, mem_req_pa,
        input  resp_valid, resp_tag, resp_asid, resp_vpn,
        input  resp_pte, resp_level,
        input  resp_page_fault, resp_access_fault
    );

    modport slave (
        input  req_valid, req_vpn, req_asid, req_tag,
        input  satp_ppn, flush,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_pte, mem_resp_error,
        input  resp_ready,
        output req_ready, mem_req_valid, mem_req_pa,
        output resp_valid, resp_tag, resp_asid, resp_vpn,
        output resp_pte, resp_level,
        output resp_page_fault, resp_access_fault
    );
endinterface

// File: rtl/sv39_ptw.sv
// Sv39 hardware page-table walker: one L2 TLB miss at a
// time, root to leaf, one outstanding PTE read.
module sv39_ptw #(
    parameter int REQ_TAG_WIDTH = 2
) (
    input logic    CLK,
    input logic    nRST,
    sv39_ptw_if.slave bus
);
    typedef struct packed {
        logic        n;
        logic [1:0]  pbmt;
        logic [6:0]  rsvd;
        logic [25:0] ppn2;
        logic [8:0]  ppn1;
        logic [8:0]  ppn0;
        logic [1:0]  rsw;
        logic        d, a, g, u, x, w, r, v;
    } big_pte_t;

    typedef struct packed {
        logic [8:0] ppn2;
        logic [8:0] ppn1;
        logic [8:0] ppn0;
        logic       d, a, g, u, x, w, r, v;
    } pte_t;

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT, RESP, DRAIN
    } state_t;

    function automatic pte_t make_small_pte(big_pte_t p);
        pte_t s;
        s.ppn2 = p.ppn2[8:0];
        s.ppn1 = p.ppn1;
        s.ppn0 = p.ppn0;
        s.d = p.d; s.a = p.a; s.g = p.g; s.u = p.u;
        s.x = p.x; s.w = p.w; s.r = p.r; s.v = p.v;
        return s;
    endfunction

    state_t                   state_q, state_d;
    logic [26:0]              vpn_q, vpn_d;
    logic [15:0]              asid_q, asid_d;
    logic [REQ_TAG_WIDTH-1:0] tag_q, tag_d;
    logic [43:0]              base_ppn_q, base_ppn_d;
    logic [1:0]               level_q, level_d;
    pte_t                     pte_q, pte_d;
    logic                     pf_q, pf_d;
    logic                     af_q, af_d;

    big_pte_t   pte_in;
    logic [8:0] vpn_sel;
    logic       bad_base;
    logic       misaligned;
    logic       hs;
    logic       unused_rsw;

    assign pte_in     = big_pte_t'(bus.mem_resp_pte);
    assign unused_rsw = ^pte_in.rsw;
    assign bad_base   = |base_ppn_q[43:27];

    // VPN slice indexing the table at the current level
    always_comb begin
        vpn_sel = vpn_q[8:0];
        unique case (1'b1)
            level_q == 2'd2: vpn_sel = vpn_q[26:18];
            level_q == 2'd1: vpn_sel = vpn_q[17:9];
            default:         vpn_sel = vpn_q[8:0];
        endcase
    end

    assign misaligned =
        (level_q == 2'd2 && (|pte_in.ppn1 || |pte_in.ppn0)) ||
        (level_q == 2'd1 && |pte_in.ppn0);

    assign bus.mem_req_pa = {base_ppn_q, 12'b0} +
                            {44'b0, vpn_sel, 3'b0};
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_tag   = tag_q;
    assign bus.resp_asid  = asid_q;
    assign bus.resp_vpn   = vpn_q;
    assign bus.resp_pte   = pte_q;
    assign bus.resp_level = level_q;
    assign bus.resp_page_fault   = pf_q;
    assign bus.resp_access_fault = af_q;

    // Walk sequencing and PTE evaluation
    always_comb begin
        state_d    = state_q;
        vpn_d      = vpn_q;
        asid_d     = asid_q;
        tag_d      = tag_q;
        base_ppn_d = base_ppn_q;
        level_d    = level_q;
        pte_d      = pte_q;
        pf_d       = pf_q;
        af_d       = af_q;
        hs         = 1'b0;
        bus.mem_req_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    vpn_d      = bus.req_vpn;
                    asid_d     = bus.req_asid;
                    tag_d      = bus.req_tag;
                    base_ppn_d = bus.satp_ppn;
                    level_d    = 2'd2;
                    pte_d      = '0;
                    pf_d       = 1'b0;
                    af_d       = 1'b0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                bus.mem_req_valid = !bad_base;
                hs = !bad_base && bus.mem_req_ready;
                if (hs && bus.flush) begin
                    state_d = DRAIN;
                end else if (bus.flush) begin
                    state_d = IDLE;
                end else if (bad_base) begin
                    af_d    = 1'b1;
                    state_d = RESP;
                end else if (hs) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.flush) begin
                    state_d = bus.mem_resp_valid ? IDLE : DRAIN;
                end else if (bus.mem_resp_valid) begin
                    state_d = RESP;
                    if (bus.mem_resp_error) begin
                        af_d = 1'b1;
                    end else if (!pte_in.v ||
                                 (!pte_in.r && pte_in.w) ||
                                 pte_in.n || |pte_in.pbmt ||
                                 |pte_in.rsvd) begin
                        pf_d = 1'b1;
                    end else if (pte_in.r || pte_in.x) begin
                        if (!pte_in.a || misaligned) begin
                            pf_d = 1'b1;
                        end else if (|pte_in.ppn2[25:9]) begin
                            af_d = 1'b1;
                        end else begin
                            pte_d = make_small_pte(pte_in);
                        end
                    end else if (level_q == 2'd0 || pte_in.d ||
                                 pte_in.a || pte_in.u) begin
                        pf_d = 1'b1;
                    end else begin
                        base_ppn_d = {pte_in.ppn2, pte_in.ppn1,
                                      pte_in.ppn0};
                        level_d    = level_q - 2'd1;
                        state_d    = REQ;
                    end
                end
            end
            RESP: begin
                if (bus.flush || bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (bus.mem_resp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and walk context registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            vpn_q      <= '0;
            asid_q     <= '0;
            tag_q      <= '0;
            base_ppn_q <= '0;
            level_q    <= '0;
            pte_q      <= '0;
            pf_q       <= 1'b0;
            af_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            vpn_q      <= vpn_d;
            asid_q     <= asid_d;
            tag_q      <= tag_d;
            base_ppn_q <= base_ppn_d;
            level_q    <= level_d;
            pte_q      <= pte_d;
            pf_q       <= pf_d;
            af_q       <= af_d;
        end
    end

    resp_only_when_waiting: assert property (
        @(posedge CLK) disable iff (!nRST)
        bus.mem_resp_valid |-> (state_q == WAIT ||
                                state_q == DRAIN));

    faults_exclusive: assert property (
        @(posedge CLK) disable iff (!nRST)
        !(pf_q && af_q));
endmodule

// File: doc/sv39_ptw.md
# sv39_ptw

Hardware Sv39 page-table walker serving L2 TLB misses. It accepts one {VPN, ASID, tag} miss at a time and issues 8-byte PTE reads to the memory side (L2 cache port) from the root PPN down to a leaf. It returns a compacted `sysp::pte_t`, the page level and fault status to the L2 TLB, which then refills the ITLB/DTLB. It sits directly downstream of the L2 TLB miss path and consumes `sysp::big_pte_t` memory data.

## Interface

Parameters:
- REQ_TAG_WIDTH, default `sysp::ITLB_L2_TLB_REQ_TAG_WIDTH` (2): requester tag width, passed through unchanged.

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- req_valid  in  1  walk request
- req_ready  out  1  walker idle; handshake when req_valid && req_ready
- req_vpn  in  27  `vpn_t`, {vpn2, vpn1, vpn0}
- req_asid  in  16  `asid_t`
- req_tag  in  REQ_TAG_WIDTH  requester tag
- satp_ppn  in  44  `big_ppn_t` root table PPN; sampled at accept
- flush  in  1  abort current walk
- mem_req_valid  out  1  PTE read request
- mem_req_ready  in  1  memory accepts request
- mem_req_pa  out  56  `big_pa56_t` PTE byte address, 8B aligned
- mem_resp_valid  in  1  PTE data return; always accepted, no ready
- mem_resp_pte  in  64  `big_pte_t`
- mem_resp_error  in  1  bus error on this return
- resp_valid  out  1  walk result
- resp_ready  in  1  consumer accepts result
- resp_tag  out  REQ_TAG_WIDTH  tag of the walk
- resp_asid  out  16  ASID of the walk
- resp_vpn  out  27  VPN of the walk
- resp_pte  out  35  `pte_t` via `make_small_pte`
- resp_level  out  2  leaf level: 0 = 4KB, 1 = 2MB, 2 = 1GB
- resp_page_fault  out  1  page fault
- resp_access_fault  out  1  access fault

## Operation

- States: IDLE, REQ, WAIT, RESP, DRAIN. There is one outstanding memory read at most.
- IDLE: req_ready = 1. On accept, latch vpn/asid/tag, set base_ppn = satp_ppn and level = 2, then go to REQ.
- REQ: mem_req_valid = 1 and mem_req_pa = {base_ppn, 12'b0} + vpn[level]*8. On mem_req_ready, go to WAIT. If base_ppn[43:27] != 0, do not issue the read; set access_fault and go to RESP.
- WAIT: on mem_resp_valid, evaluate the PTE in priority order:
  1. mem_resp_error: access fault.
  2. !v, or (!r && w), or n/pbmt/reserved nonzero: page fault.
  3. Leaf (r || x):
     - page fault if !a (no hardware A/D update);
     - page fault if the superpage is misaligned (level 2 with ppn1 or ppn0 nonzero; level 1 with ppn0 nonzero);
     - access fault if big_ppn2[25:9] != 0;
     - otherwise success. resp_level = level and resp_pte = make_small_pte(PTE).
  4. Pointer:
     - page fault if level == 0, or if any of d, a, u is set;
     - otherwise base_ppn = {big_ppn2, ppn1, ppn0}, level -= 1, go to REQ.
- Any fault or leaf goes to RESP. On a fault, resp_pte = 0 and resp_level = the faulting level.
- RESP: resp_valid = 1 with all result fields stable until resp_ready, then go to IDLE. page_fault and access_fault are mutually exclusive.
- flush:
  - in REQ before handshake, or in RESP: go to IDLE next cycle and drop the result;
  - in WAIT, or in REQ with a same-cycle handshake: go to DRAIN, discard the next mem_resp, then go to IDLE;
  - in IDLE: no effect, and a same-cycle req is still accepted.
- flush has priority over all other transitions except the REQ handshake already in flight.

## Timing

- Reset values: req_ready = 1; every other output = 0; state = IDLE.
- req_ready is combinational from state only.
- mem_req_valid rises in the cycle after entering REQ. The address is held stable while mem_req_valid && !mem_req_ready.
- Each level costs at least 2 cycles (REQ handshake, then WAIT response with zero latency).
- Minimum 3-level walk: accept at T, mem requests at T+1, T+3, T+5, resp_valid at T+7.
- Minimum 1-level walk (1GB leaf): resp_valid at T+3.
- mem_resp_valid outside WAIT/DRAIN is illegal; assert on it.
- No new request is accepted in the cycle resp_ready is taken; that request is accepted the following cycle.

## Test plan

- 4KB walk: satp_ppn = 0x80000, vpn = {0x001, 0x002, 0x003}.
  - Memory returns pointer ppn 0x80001, then pointer 0x80002, then leaf ppn 0x12345 with flags VRWXAD.
  - Requested addresses are 0x8000_0008, 0x8000_1010, 0x8000_2018.
  - resp_level = 0, ppn = 0x12345, no faults, resp_valid at T+7.
- 1GB leaf: level-2 PTE ppn = {0x005, 0, 0} with VRXA → resp_level = 2, success, resp_valid at T+3. Same PTE with ppn0 = 1 → page_fault, level 2.
- Faults:
  - V = 0 at level 1 → page_fault.
  - Pointer at level 0 → page_fault.
  - Leaf with big_ppn2 = 0x200 → access_fault.
  - mem_resp_error = 1 → access_fault.
  - R = 0, W = 1 → page_fault.
- Backpressure: mem_req_ready held low 5 cycles → mem_req_pa stable. resp_ready held low 4 cycles → result stable and req_ready = 0.
- Flush in WAIT: flush at WAIT, response arrives 3 cycles later and is discarded, no resp_valid, then req_ready = 1. Flush in RESP drops the result.
- Reset mid-walk: deassert nRST during WAIT → all outputs 0 and req_ready = 1 immediately. A fresh walk afterwards completes correctly.
